// File: rtl/mem_master_pkg.sv
// Shared types and constants for the memory initiator.
package mem_master_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned ADDR_LEN_DEF = 10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_e;

    // Size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane extraction/extension for loads and lane merge for sub-word stores.
module mem_lane_align
    import mem_master_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [1:0]      addr_lo_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] rdata_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_data_o,
    output logic [XLEN-1:0] merged_o
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] lane_data;

    // Shift the addressed lane down for loads, and the store lane up into place for merges.
    always_comb begin
        shamt     = {addr_lo_i, 3'b000};
        shifted   = rdata_i >> shamt;
        lane_data = wdata_i << shamt;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {{(XLEN-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
                lane_mask   = {{(XLEN-8){1'b0}}, 8'hFF} << shamt;
            end
            SZ_HALF: begin
                load_data_o = {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
                lane_mask   = {{(XLEN-16){1'b0}}, 16'hFFFF} << shamt;
            end
            default: begin
                // Word accesses are always aligned here, so shamt is zero.
                load_data_o = shifted;
                lane_mask   = '1;
            end
        endcase
        merged_o = (rdata_i & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/mem_master.sv
// Core-side initiator for the single-port synchronous memory macro.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned ADDR_LEN = ADDR_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic                mem_cs_n,
    output logic                mem_we_n,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata
);

    state_e state_q, state_d;

    // Holding registers for the accepted request.
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic                mem_cs_n_q, mem_cs_n_d;
    logic                mem_we_n_q, mem_we_n_d;
    logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged;

    // Address bits above the memory span wrap and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_LEN+2];

    mem_lane_align #(
        .XLEN (XLEN)
    ) u_lane_align (
        .addr_lo_i   (addr_lo_q),
        .size_i      (size_q),
        .unsigned_i  (uns_q),
        .rdata_i     (mem_rdata),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    // Next-state logic; memory and response outputs are computed one cycle ahead and registered.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_lo_d    = addr_lo_q;
        wdata_d      = wdata_q;
        mem_cs_n_d   = 1'b1;
        mem_we_n_d   = 1'b1;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d    = req_size;
                    uns_d     = req_unsigned;
                    addr_lo_d = req_addr[1:0];
                    wdata_d   = req_wdata;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        mem_cs_n_d = 1'b0;
                        mem_addr_d = req_addr[ADDR_LEN+1:2];
                        if (!req_we) begin
                            state_d = READ;
                        end else if (req_size == SZ_BYTE || req_size == SZ_HALF) begin
                            state_d = RMW_RD;
                        end else begin
                            state_d     = WRITE;
                            mem_we_n_d  = 1'b0;
                            mem_wdata_d = req_wdata;
                        end
                    end
                end
            end
            READ: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RMW_RD: begin
                state_d     = RMW_WR;
                mem_cs_n_d  = 1'b0;
                mem_we_n_d  = 1'b0;
                mem_wdata_d = merged;
            end
            RMW_WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            size_q       <= SZ_WORD;
            uns_q        <= 1'b0;
            addr_lo_q    <= 2'b00;
            wdata_q      <= '0;
            mem_cs_n_q   <= 1'b1;
            mem_we_n_q   <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_lo_q    <= addr_lo_d;
            wdata_q      <= wdata_d;
            mem_cs_n_q   <= mem_cs_n_d;
            mem_we_n_q   <= mem_we_n_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_cs_n   = mem_cs_n_q;
    assign mem_we_n   = mem_we_n_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural model of the memory macro.
module tb_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_cs_n;
    logic        mem_we_n;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [1024];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_cs;
        int          exp_wr;
    } vec_t;

    vec_t vecs [22];

    mem_master dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_cs_n     (mem_cs_n),
        .mem_we_n     (mem_we_n),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro: write on rising edge, read data registered on falling edge.
    always @(posedge clk) begin
        if (!mem_cs_n && !mem_we_n) mem[mem_addr] <= mem_wdata;
    end
    always @(negedge clk) begin
        if (!mem_cs_n) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input int exp_cs, input int exp_wr);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_cs = exp_cs; v.exp_wr = exp_wr;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int          lat = 0;
        int          cs_cnt = 0;
        int          wr_cnt = 0;
        int          waits = 0;
        logic        addr_bad = 1'b0;
        logic        got = 1'b0;
        logic [31:0] rd = '0;
        logic        er = 1'b0;
        logic [9:0]  exp_wa;
        exp_wa = v.addr[11:2];
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) check($sformatf("v%0d_ready_timeout", idx), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 1; i <= 8 && !got; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (!mem_cs_n) begin
                cs_cnt++;
                if (!mem_we_n) wr_cnt++;
                if (mem_addr !== exp_wa) addr_bad = 1'b1;
            end
            if (resp_valid) begin
                got = 1'b1; lat = i; rd = resp_rdata; er = resp_err;
            end
        end
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
        check($sformatf("v%0d_err", idx), {31'd0, er}, {31'd0, v.exp_err});
        check($sformatf("v%0d_cs_cycles", idx), cs_cnt, v.exp_cs);
        check($sformatf("v%0d_wr_cycles", idx), wr_cnt, v.exp_wr);
        check($sformatf("v%0d_addr_bad", idx), {31'd0, addr_bad}, 32'd0);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_pulse_end", idx), {31'd0, resp_valid}, 32'd0);
        check($sformatf("v%0d_ready_back", idx), {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int acc;
        int rsp;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem_rdata = '0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;

        //         we    sz     u     addr        wdata         exp_rdata     err  lat cs wr
        vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 1);
        vecs[1]  = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0);
        vecs[2]  = mk(1'b1, 2'b10, 1'b0, 32'h10,   32'h11223344, 32'h0,        1'b0, 2, 1, 1);
        vecs[3]  = mk(1'b1, 2'b00, 1'b0, 32'h12,   32'h000000AA, 32'h0,        1'b0, 3, 2, 1);
        vecs[4]  = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h11AA3344, 1'b0, 2, 1, 0);
        vecs[5]  = mk(1'b1, 2'b00, 1'b0, 32'h11,   32'hDEADBE55, 32'h0,        1'b0, 3, 2, 1);
        vecs[6]  = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h11AA5544, 1'b0, 2, 1, 0);
        vecs[7]  = mk(1'b1, 2'b10, 1'b0, 32'h20,   32'h80FF7F01, 32'h0,        1'b0, 2, 1, 1);
        vecs[8]  = mk(1'b0, 2'b00, 1'b0, 32'h21,   32'h0,        32'h0000007F, 1'b0, 2, 1, 0);
        vecs[9]  = mk(1'b0, 2'b00, 1'b0, 32'h22,   32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 0);
        vecs[10] = mk(1'b0, 2'b00, 1'b1, 32'h23,   32'h0,        32'h00000080, 1'b0, 2, 1, 0);
        vecs[11] = mk(1'b0, 2'b01, 1'b0, 32'h22,   32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0);
        vecs[12] = mk(1'b0, 2'b01, 1'b1, 32'h22,   32'h0,        32'h000080FF, 1'b0, 2, 1, 0);
        vecs[13] = mk(1'b0, 2'b10, 1'b0, 32'h13,   32'h0,        32'h0,        1'b1, 1, 0, 0);
        vecs[14] = mk(1'b1, 2'b01, 1'b0, 32'h05,   32'h1234,     32'h0,        1'b1, 1, 0, 0);
        vecs[15] = mk(1'b1, 2'b01, 1'b0, 32'h22,   32'h0000BEEF, 32'h0,        1'b0, 3, 2, 1);
        vecs[16] = mk(1'b0, 2'b11, 1'b0, 32'h20,   32'h0,        32'hBEEF7F01, 1'b0, 2, 1, 0);
        vecs[17] = mk(1'b0, 2'b10, 1'b0, 32'h1020, 32'h0,        32'hBEEF7F01, 1'b0, 2, 1, 0);
        vecs[18] = mk(1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        32'h00000044, 1'b0, 2, 1, 0);
        vecs[19] = mk(1'b0, 2'b01, 1'b0, 32'h20,   32'h0,        32'h00007F01, 1'b0, 2, 1, 0);
        vecs[20] = mk(1'b0, 2'b00, 1'b0, 32'h23,   32'h0,        32'hFFFFFFBE, 1'b0, 2, 1, 0);
        vecs[21] = mk(1'b0, 2'b01, 1'b1, 32'h13,   32'h0,        32'h0,        1'b1, 1, 0, 0);

        // Reset values.
        rst = 1'b1;
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_cs_n", {31'd0, mem_cs_n}, 32'd1);
        check("rst_we_n", {31'd0, mem_we_n}, 32'd1);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) run_vec(i, vecs[i]);

        // Reset asserted asynchronously while in RMW_RD.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rmw_rd_cs_low", {31'd0, mem_cs_n}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cs_n", {31'd0, mem_cs_n}, 32'd1);
        check("async_rst_we_n", {31'd0, mem_we_n}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_no_resp%0d", i), {31'd0, resp_valid}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        // The dropped byte store must not have reached memory.
        run_vec(100, mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11AA5544, 1'b0, 2, 1, 0));

        // Continuous req_valid: one acceptance per three cycles, one response per acceptance.
        acc = 0;
        rsp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = '0;
        for (int i = 0; i < 12; i++) begin
            if (req_ready) acc++;
            @(posedge clk);
            #1;
            if (resp_valid) begin
                rsp++;
                check($sformatf("b2b_rdata%0d", rsp), resp_rdata, 32'h11AA5544);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc, 32'd4);
        check("b2b_responses", rsp, 32'd4);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
